npc_predict_unit: RTL and testbench
===================================

Name: npc_predict_unit

Overview:
Parametrised next-PC unit combining branch/jump resolution with a direct-mapped branch predictor (2-bit BHT plus BTB).
- IF stage: looks up the fetch PC and supplies a predicted next PC.
- EX stage: resolves the actual outcome, raises a redirect on mispredict, and trains the tables.
- Supersedes the purely combinational NPC control; adds unsigned compares, prediction state and table training.

Parameters:
XLEN, 32, datapath/PC width
IDX_W, 6, log2 of table entries (2^IDX_W entries)
CNT_W, 2, saturating counter width (>=2)

Ports:
cpu_clk  in  1  clock
cpu_rst  in  1  synchronous active-high reset
if_pc  in  XLEN  fetch PC
pred_taken  out  1  prediction for if_pc
pred_npc  out  XLEN  predicted next PC (BTB target if pred_taken, else if_pc+4)
ex_valid  in  1  EX holds a valid instruction this cycle
ex_pc  in  XLEN  PC of EX instruction
ex_pred_taken  in  1  prediction carried down the pipe with this instruction
ex_pred_npc  in  XLEN  predicted next PC carried down the pipe
branch  in  3  000 none, 001 beq, 011 bne, 101 blt, 111 bge, 100 bltu, 110 bgeu
jump  in  2  00 none, 01 jalr, 11 jal
zero  in  1  ALU result zero
sgn  in  1  signed less-than flag
ltu  in  1  unsigned less-than flag
pc_imm  in  XLEN  ex_pc + immediate
alu_c  in  XLEN  ALU result (jalr target source)
redirect  out  1  mispredict; fetch must take redirect_pc and flush IF/ID
redirect_pc  out  XLEN  correct next PC

Behaviour:
- Clock and reset: single clock cpu_clk; reset cpu_rst is synchronous, active-high.
- Indexing:
  - idx = pc[IDX_W+1:2]; tag = pc[XLEN-1:IDX_W+2].
  - Arrays: valid[2^IDX_W], tag, target, cnt[CNT_W].
- Lookup (combinational, zero latency):
  - hit = valid[idx] && tag match.
  - pred_taken = hit && cnt MSB = 1.
  - pred_npc = pred_taken ? target[idx] : if_pc+4 (mod 2^XLEN, wraps).
- Resolution (combinational, when ex_valid):
  - act_taken = jump[0] | (beq&zero) | (bne&!zero) | (blt&sgn) | (bge&!sgn) | (bltu&ltu) | (bgeu&!ltu).
  - act_tgt = (jump==01) ? {alu_c[XLEN-1:1],1'b0} : pc_imm.
  - act_npc = act_taken ? act_tgt : ex_pc+4.
  - redirect = ex_valid && (ex_pred_npc != act_npc); redirect_pc = act_npc.
  - When ex_valid=0: redirect=0, redirect_pc=0.
- Training (posedge cpu_clk, when ex_valid && (branch!=000 || jump!=00)), at idx/tag of ex_pc:
  - Tag miss + act_taken: allocate. Set valid=1, tag, target=act_tgt, cnt = jump ? max : 2^(CNT_W-1) (weakly taken).
  - Tag miss + not taken: no allocation.
  - Hit: cnt saturating +1 if taken, -1 if not (clamp at 0 and 2^CNT_W-1); target updated to act_tgt if taken.
  - jal/jalr hit: cnt forced to max.
  - Non-control instructions never touch the tables.
- Simultaneous lookup and update of the same index: lookup returns the pre-edge contents (no bypass).
- Reset:
  - All valid=0, all cnt = 2^(CNT_W-1)-1 (weakly not-taken).
  - Therefore pred_taken=0 and pred_npc=if_pc+4 in the first cycle after reset.
  - Reset wins over a concurrent update.
  - Reset mid-operation discards all history; no other state exists.
- Invalid branch encodings (010) are treated as not taken and do not train.

Optional Feature:
BP_STATS_EN
- Defined: adds outputs stat_ctrl[31:0] (trained control instructions) and stat_miss[31:0] (cycles with redirect=1).
  - Both count on posedge while ex_valid; wrap at 2^32; cleared by cpu_rst.
- Undefined: neither the ports nor the counters exist; all other behaviour is identical.

Decomposition:
- Shared package/header holds:
  - BR_* encodings: NONE=000, BEQ=001, BNE=011, BLT=101, BGE=111, BLTU=100, BGEU=110.
  - JMP_* encodings: NONE=00, JALR=01, JAL=11.
  - The PC increment constant (4).
- One natural sub-module: npc_resolve.
  - Purely combinational: computes act_taken, act_tgt and act_npc.
  - Reusable and unit-testable on its own.
- Table storage and training stay in npc_predict_unit.

Test Plan:
1. After reset, if_pc=0x100 -> pred_taken=0, pred_npc=0x104. EX beq at 0x100 with zero=1, pc_imm=0x80, ex_pred_npc=0x104 -> redirect=1, redirect_pc=0x80. Next cycle if_pc=0x100 -> pred_taken=1, pred_npc=0x80.
2. From the state after scenario 1, the same beq not taken twice (ex_pred_npc=0x80, then 0x104) -> first redirect_pc=0x104. After the second, lookup of 0x100 gives pred_taken=0 (cnt 2->1->0). A third not-taken keeps cnt at 0 (saturation).
3. jalr at 0x200 with alu_c=0x1235 -> redirect_pc=0x1234. Subsequent lookup of 0x200 gives pred_npc=0x1234 with cnt=3.
4. Aliasing: train 0x100 taken, then lookup 0x100+(4<<IDX_W) -> tag mismatch, pred_taken=0.
5. bltu with ltu=1, sgn=0 -> taken. bgeu with ltu=1 -> not taken. Correct prediction (ex_pred_npc==act_npc) -> redirect=0.
6. Assert cpu_rst in the same cycle as a taken training update -> entry remains invalid. With BP_STATS_EN defined, both stat counters read 0.

Source files
------------

// File: rtl/npc_predict_unit_pkg.sv
// Shared encodings and helpers for the next-PC predict/resolve slice.
package npc_predict_unit_pkg;

    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_BEQ  = 3'b001;
    localparam logic [2:0] BR_BNE  = 3'b011;
    localparam logic [2:0] BR_BLT  = 3'b101;
    localparam logic [2:0] BR_BGE  = 3'b111;
    localparam logic [2:0] BR_BLTU = 3'b100;
    localparam logic [2:0] BR_BGEU = 3'b110;

    localparam logic [1:0] JMP_NONE = 2'b00;
    localparam logic [1:0] JMP_JALR = 2'b01;
    localparam logic [1:0] JMP_JAL  = 2'b11;

    localparam int PC_INC = 4;

    // 3'b010 is not a real branch: it neither resolves taken nor trains.
    function automatic logic is_branch(input logic [2:0] br);
        return (br == BR_BEQ) || (br == BR_BNE) || (br == BR_BLT) ||
               (br == BR_BGE) || (br == BR_BLTU) || (br == BR_BGEU);
    endfunction

    function automatic logic is_jump(input logic [1:0] jmp);
        return (jmp == JMP_JALR) || (jmp == JMP_JAL);
    endfunction

endpackage

// File: rtl/npc_resolve.sv
// Combinational branch/jump resolution: actual direction, target and next PC.
module npc_resolve
    import npc_predict_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      branch,
    input  logic [1:0]      jump,
    input  logic            zero,
    input  logic            sgn,
    input  logic            ltu,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] pc_imm,
    input  logic [XLEN-1:0] alu_c,
    output logic            act_taken,
    output logic [XLEN-1:0] act_tgt,
    output logic [XLEN-1:0] act_npc
);

    logic br_taken;

    always_comb begin
        br_taken = 1'b0;
        case (branch)
            BR_BEQ:  br_taken = zero;
            BR_BNE:  br_taken = !zero;
            BR_BLT:  br_taken = sgn;
            BR_BGE:  br_taken = !sgn;
            BR_BLTU: br_taken = ltu;
            BR_BGEU: br_taken = !ltu;
            default: br_taken = 1'b0;
        endcase
    end

    assign act_taken = is_jump(jump) || br_taken;
    // jalr clears bit 0 of the computed address; everything else is pc-relative.
    assign act_tgt   = (jump == JMP_JALR) ? (alu_c & ~XLEN'(1)) : pc_imm;
    assign act_npc   = act_taken ? act_tgt : ex_pc + XLEN'(PC_INC);

endmodule

// File: rtl/npc_predict_unit.sv
// Next-PC unit: direct-mapped BHT/BTB lookup at IF, resolve + train at EX.
// Optional BP_STATS_EN adds stat_ctrl / stat_miss event counters.
module npc_predict_unit
    import npc_predict_unit_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int IDX_W = 6,
    parameter int CNT_W = 2
) (
    input  logic            cpu_clk,
    input  logic            cpu_rst,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_npc,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_npc,
    input  logic [2:0]      branch,
    input  logic [1:0]      jump,
    input  logic            zero,
    input  logic            sgn,
    input  logic            ltu,
    input  logic [XLEN-1:0] pc_imm,
    input  logic [XLEN-1:0] alu_c,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc
`ifdef BP_STATS_EN
    ,
    output logic [31:0]     stat_ctrl,
    output logic [31:0]     stat_miss
`endif
);

    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = XLEN - IDX_W - 2;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_WT  = {1'b1, {(CNT_W-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_WNT = {1'b0, {(CNT_W-1){1'b1}}};

    logic             valid_q [ENTRIES];
    logic [TAG_W-1:0] tag_q   [ENTRIES];
    logic [XLEN-1:0]  tgt_q   [ENTRIES];
    logic [CNT_W-1:0] cnt_q   [ENTRIES];

    logic [IDX_W-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0] if_tag, ex_tag;
    logic             if_hit, ex_hit, ex_is_jmp, train;
    logic             act_taken;
    logic [XLEN-1:0]  act_tgt, act_npc;
    logic             unused_pred_dir;

    // Mispredict detection compares full next-PCs, so the carried direction bit is redundant here.
    assign unused_pred_dir = ex_pred_taken;

    assign if_idx = if_pc[IDX_W+1:2];
    assign if_tag = if_pc[XLEN-1:IDX_W+2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign ex_tag = ex_pc[XLEN-1:IDX_W+2];

    assign if_hit     = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign pred_taken = if_hit && cnt_q[if_idx][CNT_W-1];
    assign pred_npc   = pred_taken ? tgt_q[if_idx] : if_pc + XLEN'(PC_INC);

    npc_resolve #(.XLEN(XLEN)) u_resolve (
        .branch    (branch),
        .jump      (jump),
        .zero      (zero),
        .sgn       (sgn),
        .ltu       (ltu),
        .ex_pc     (ex_pc),
        .pc_imm    (pc_imm),
        .alu_c     (alu_c),
        .act_taken (act_taken),
        .act_tgt   (act_tgt),
        .act_npc   (act_npc)
    );

    assign redirect    = ex_valid && (ex_pred_npc != act_npc);
    assign redirect_pc = ex_valid ? act_npc : '0;

    assign ex_is_jmp = is_jump(jump);
    assign train     = ex_valid && (is_branch(branch) || ex_is_jmp);
    assign ex_hit    = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    // Tables are written at the edge only, so a same-index lookup sees pre-edge contents.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                cnt_q[i]   <= CNT_WNT;
            end
        end else if (train) begin
            if (ex_hit) begin
                if (ex_is_jmp)
                    cnt_q[ex_idx] <= CNT_MAX;
                else if (act_taken && cnt_q[ex_idx] != CNT_MAX)
                    cnt_q[ex_idx] <= cnt_q[ex_idx] + CNT_W'(1);
                else if (!act_taken && cnt_q[ex_idx] != '0)
                    cnt_q[ex_idx] <= cnt_q[ex_idx] - CNT_W'(1);
                if (act_taken)
                    tgt_q[ex_idx] <= act_tgt;
            end else if (act_taken) begin
                valid_q[ex_idx] <= 1'b1;
                tag_q[ex_idx]   <= ex_tag;
                tgt_q[ex_idx]   <= act_tgt;
                cnt_q[ex_idx]   <= ex_is_jmp ? CNT_MAX : CNT_WT;
            end
        end
    end

`ifdef BP_STATS_EN
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            stat_ctrl <= '0;
            stat_miss <= '0;
        end else begin
            if (train)    stat_ctrl <= stat_ctrl + 32'd1;
            if (redirect) stat_miss <= stat_miss + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_npc_predict_unit.sv
// Directed self-checking bench for npc_predict_unit (default parameters).
module tb_npc_predict_unit;

    localparam int XLEN  = 32;
    localparam int IDX_W = 6;

    logic            cpu_clk = 1'b0;
    logic            cpu_rst = 1'b1;
    logic [XLEN-1:0] if_pc = '0;
    logic            pred_taken;
    logic [XLEN-1:0] pred_npc;
    logic            ex_valid = 1'b0;
    logic [XLEN-1:0] ex_pc = '0;
    logic            ex_pred_taken = 1'b0;
    logic [XLEN-1:0] ex_pred_npc = '0;
    logic [2:0]      branch = 3'b000;
    logic [1:0]      jump = 2'b00;
    logic            zero = 1'b0, sgn = 1'b0, ltu = 1'b0;
    logic [XLEN-1:0] pc_imm = '0, alu_c = '0;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
`ifdef BP_STATS_EN
    logic [31:0]     stat_ctrl, stat_miss;
`endif

    int checks = 0;
    int failures = 0;

    always #5 cpu_clk = ~cpu_clk;

    npc_predict_unit #(.XLEN(XLEN), .IDX_W(IDX_W), .CNT_W(2)) dut (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_npc(pred_npc),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_pred_taken(ex_pred_taken),
        .ex_pred_npc(ex_pred_npc), .branch(branch), .jump(jump),
        .zero(zero), .sgn(sgn), .ltu(ltu), .pc_imm(pc_imm), .alu_c(alu_c),
        .redirect(redirect), .redirect_pc(redirect_pc)
`ifdef BP_STATS_EN
        , .stat_ctrl(stat_ctrl), .stat_miss(stat_miss)
`endif
    );

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic set_ex(input logic v, input logic [31:0] pc, input logic [2:0] br,
                          input logic [1:0] j, input logic z, input logic s, input logic l,
                          input logic [31:0] imm, input logic [31:0] alu, input logic [31:0] pnpc);
        ex_valid = v; ex_pc = pc; branch = br; jump = j; zero = z; sgn = s; ltu = l;
        pc_imm = imm; alu_c = alu; ex_pred_npc = pnpc; ex_pred_taken = (pnpc != pc + 32'd4);
        #1;
    endtask

    task automatic idle();
        set_ex(1'b0, 32'h0, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic look(input logic [31:0] pc);
        if_pc = pc;
        #1;
    endtask

    task automatic test_reset();
        cpu_rst = 1'b1; idle(); tick(); tick();
        cpu_rst = 1'b0; look(32'h100);
        checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL rst_pred_taken got=%0h exp=0", pred_taken); end
        checks++; if (pred_npc !== 32'h104) begin failures++; $display("FAIL rst_pred_npc got=%0h exp=104", pred_npc); end
        checks++; if (redirect !== 1'b0 || redirect_pc !== 32'h0) begin failures++; $display("FAIL rst_idle_redirect got=%0h/%0h exp=0/0", redirect, redirect_pc); end
        look(32'hFFFF_FFFC);
        checks++; if (pred_npc !== 32'h0) begin failures++; $display("FAIL pc_wrap got=%0h exp=0", pred_npc); end
    endtask

    task automatic test_beq_taken();
        look(32'h100);
        set_ex(1'b1, 32'h100, 3'b001, 2'b00, 1'b1, 1'b0, 1'b0, 32'h80, 32'h0, 32'h104);
        checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h80) begin failures++; $display("FAIL beq_redirect got=%0h/%0h exp=1/80", redirect, redirect_pc); end
        checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL same_idx_no_bypass got=%0h exp=0", pred_taken); end
        tick(); idle();
        checks++; if (pred_taken !== 1'b1 || pred_npc !== 32'h80) begin failures++; $display("FAIL beq_learned got=%0h/%0h exp=1/80", pred_taken, pred_npc); end
    endtask

    task automatic test_not_taken_sat();
        look(32'h100);
        set_ex(1'b1, 32'h100, 3'b001, 2'b00, 1'b0, 1'b0, 1'b0, 32'h80, 32'h0, 32'h80);
        checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h104) begin failures++; $display("FAIL nt1_redirect got=%0h/%0h exp=1/104", redirect, redirect_pc); end
        tick();
        set_ex(1'b1, 32'h100, 3'b001, 2'b00, 1'b0, 1'b0, 1'b0, 32'h80, 32'h0, 32'h104);
        checks++; if (redirect !== 1'b0) begin failures++; $display("FAIL nt2_correct got=%0h exp=0", redirect); end
        tick(); idle();
        checks++; if (pred_taken !== 1'b0 || pred_npc !== 32'h104) begin failures++; $display("FAIL nt2_pred got=%0h/%0h exp=0/104", pred_taken, pred_npc); end
        set_ex(1'b1, 32'h100, 3'b001, 2'b00, 1'b0, 1'b0, 1'b0, 32'h80, 32'h0, 32'h104);
        tick(); idle();
        checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL nt3_sat_low got=%0h exp=0", pred_taken); end
        // cnt 0 -> 1 must still predict not-taken; a wrap to 3 would show here
        set_ex(1'b1, 32'h100, 3'b001, 2'b00, 1'b1, 1'b0, 1'b0, 32'h80, 32'h0, 32'h104);
        tick(); idle();
        checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL sat_t1 got=%0h exp=0", pred_taken); end
        set_ex(1'b1, 32'h100, 3'b001, 2'b00, 1'b1, 1'b0, 1'b0, 32'h80, 32'h0, 32'h104);
        tick(); idle();
        checks++; if (pred_taken !== 1'b1 || pred_npc !== 32'h80) begin failures++; $display("FAIL sat_t2 got=%0h/%0h exp=1/80", pred_taken, pred_npc); end
    endtask

    task automatic test_jumps();
        look(32'h200);
        set_ex(1'b1, 32'h200, 3'b000, 2'b01, 1'b0, 1'b0, 1'b0, 32'h999, 32'h1235, 32'h204);
        checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h1234) begin failures++; $display("FAIL jalr_redirect got=%0h/%0h exp=1/1234", redirect, redirect_pc); end
        tick(); idle();
        checks++; if (pred_taken !== 1'b1 || pred_npc !== 32'h1234) begin failures++; $display("FAIL jalr_learned got=%0h/%0h exp=1/1234", pred_taken, pred_npc); end
        // cnt must be 3: one not-taken leaves it at 2 (still taken)
        set_ex(1'b1, 32'h200, 3'b001, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h1234);
        tick(); idle();
        checks++; if (pred_taken !== 1'b1 || pred_npc !== 32'h1234) begin failures++; $display("FAIL jalr_cnt_max got=%0h/%0h exp=1/1234", pred_taken, pred_npc); end
        set_ex(1'b1, 32'h300, 3'b000, 2'b11, 1'b0, 1'b0, 1'b0, 32'h400, 32'h777, 32'h304);
        checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h400) begin failures++; $display("FAIL jal_redirect got=%0h/%0h exp=1/400", redirect, redirect_pc); end
        tick(); idle();
    endtask

    task automatic test_alias();
        set_ex(1'b1, 32'h100, 3'b001, 2'b00, 1'b1, 1'b0, 1'b0, 32'h80, 32'h0, 32'h104);
        tick(); idle(); look(32'h100);
        checks++; if (pred_taken !== 1'b1 || pred_npc !== 32'h80) begin failures++; $display("FAIL alias_own got=%0h/%0h exp=1/80", pred_taken, pred_npc); end
        look(32'h100 + (32'd4 << IDX_W));
        checks++; if (pred_taken !== 1'b0 || pred_npc !== 32'h204) begin failures++; $display("FAIL alias_other got=%0h/%0h exp=0/204", pred_taken, pred_npc); end
    endtask

    task automatic test_compares();
        set_ex(1'b1, 32'h40, 3'b100, 2'b00, 1'b0, 1'b0, 1'b1, 32'h20, 32'h0, 32'h20);
        checks++; if (redirect !== 1'b0 || redirect_pc !== 32'h20) begin failures++; $display("FAIL bltu_taken got=%0h/%0h exp=0/20", redirect, redirect_pc); end
        tick(); idle(); look(32'h40);
        checks++; if (pred_taken !== 1'b1 || pred_npc !== 32'h20) begin failures++; $display("FAIL bltu_alloc got=%0h/%0h exp=1/20", pred_taken, pred_npc); end
        set_ex(1'b1, 32'h44, 3'b110, 2'b00, 1'b0, 1'b0, 1'b1, 32'h20, 32'h0, 32'h48);
        checks++; if (redirect !== 1'b0 || redirect_pc !== 32'h48) begin failures++; $display("FAIL bgeu_nt got=%0h/%0h exp=0/48", redirect, redirect_pc); end
        set_ex(1'b1, 32'h44, 3'b101, 2'b00, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 32'h48);
        checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h10) begin failures++; $display("FAIL blt_taken got=%0h/%0h exp=1/10", redirect, redirect_pc); end
        set_ex(1'b1, 32'h44, 3'b111, 2'b00, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 32'h48);
        checks++; if (redirect_pc !== 32'h48) begin failures++; $display("FAIL bge_nt got=%0h exp=48", redirect_pc); end
        set_ex(1'b1, 32'h44, 3'b011, 2'b00, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 32'h48);
        checks++; if (redirect_pc !== 32'h10) begin failures++; $display("FAIL bne_taken got=%0h exp=10", redirect_pc); end
        set_ex(1'b1, 32'h50, 3'b010, 2'b00, 1'b1, 1'b1, 1'b1, 32'h10, 32'h0, 32'h10);
        checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h54) begin failures++; $display("FAIL invalid_br got=%0h/%0h exp=1/54", redirect, redirect_pc); end
        set_ex(1'b0, 32'h60, 3'b001, 2'b00, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 32'h64);
        checks++; if (redirect !== 1'b0 || redirect_pc !== 32'h0) begin failures++; $display("FAIL ex_invalid got=%0h/%0h exp=0/0", redirect, redirect_pc); end
        tick(); idle(); look(32'h60);
        checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL ex_invalid_notrain got=%0h exp=0", pred_taken); end
    endtask

    task automatic test_reset_collision();
        cpu_rst = 1'b1;
        set_ex(1'b1, 32'h80, 3'b001, 2'b00, 1'b1, 1'b0, 1'b0, 32'h500, 32'h0, 32'h84);
        tick(); cpu_rst = 1'b0; idle(); look(32'h80);
        checks++; if (pred_taken !== 1'b0 || pred_npc !== 32'h84) begin failures++; $display("FAIL rst_wins got=%0h/%0h exp=0/84", pred_taken, pred_npc); end
        look(32'h40);
        checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL rst_history got=%0h exp=0", pred_taken); end
`ifdef BP_STATS_EN
        checks++; if (stat_ctrl !== 32'h0 || stat_miss !== 32'h0) begin failures++; $display("FAIL rst_stats got=%0h/%0h exp=0/0", stat_ctrl, stat_miss); end
`endif
    endtask

    initial begin
        test_reset();
        test_beq_taken();
        test_not_taken_sat();
        test_jumps();
        test_alias();
        test_compares();
        test_reset_collision();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
